uc_jogo_principal_multiacao: RTL and testbench
==============================================

Name: uc_jogo_principal_multiacao

Overview:
- Next-generation top-level game control unit; generalises the main-game FSM from fixed tiro/especial inputs to N_ACOES action channels.
- Adds internal per-channel cooldown counters, fixed-priority arbitration, a pause mode, multi-bit lives, a registration watchdog and restart from game over.
- Sits above the asteroid/shot movement coordinator and one registration sub-unit per action channel; drives their start pulses and datapath resets.

Parameters:
N_ACOES, 2, number of action channels (bit 0 highest priority)
CD_W, 8, cooldown counter width
COOLDOWN, {8'd20,8'd5}, packed N_ACOES*CD_W vector; slice i = cooldown cycles of channel i (bit 0 at LSB slice)
VIDAS_W, 2, width of lives count
TIMEOUT, 255, max cycles waiting for fim_registra; must be >=1 and fit in 8 bits

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; 0 forces INICIAL and output reset values
iniciar  in  1  start / restart game
pausar  in  1  level; 1 requests pause
vidas  in  VIDAS_W  remaining lives; 0 = game over
ocorreu_jogada  in  1  a player input is pending
acao_pedida  in  N_ACOES  per-channel action request, sampled in SALVA2
fim_movimentacao  in  1  movement coordinator finished
fim_registra  in  N_ACOES  per-channel registration done
enable_reg_jogada  out  1  load play register
reset_reg_jogada  out  1  clear play register
reset_elementos  out  1  clear asteroid/shot/lives counters, score, sub-machines
inicia_movimentacao  out  1  enable movement coordinator
termina  out  1  request movement coordinator to finish its cycle
inicia_registra  out  N_ACOES  one-hot start pulse to the selected channel
acao_ativa  out  N_ACOES  registered one-hot selected channel, 0 if none
pausado  out  1  in PAUSA
pronto  out  1  in FIM_JOGO
erro  out  1  in ERRO
db_estado  out  5  state code

Behaviour:
- Moore FSM; all outputs decoded from state except acao_ativa (register). While reset=0: state INICIAL, acao_ativa=0, every output 0, db_estado=0, cooldown counters 0, watchdog 0.
- States/db codes: INICIAL 0, INICIALIZA 1, ESPERA_JOGADA 2, REGISTRA 3, TERMINA_MOV 4, ESPERA_REGISTRA 5, FIM_JOGO 6, INICIA_REGISTRA 7, SALVA1 8, SALVA2 9, PAUSA 10, ESPERA_ENVIAR 12, RESETA_JOGADA 13, ERRO 31. Unreachable codes go to ERRO.
- Transitions:
  - INICIAL: iniciar -> INICIALIZA, else stay.
  - INICIALIZA -> ESPERA_JOGADA.
  - ESPERA_JOGADA, priority order: vidas==0 -> ESPERA_ENVIAR; pausar -> PAUSA; ocorreu_jogada -> RESETA_JOGADA; else stay.
  - PAUSA: pausar=0 -> ESPERA_JOGADA, else stay.
  - RESETA_JOGADA -> REGISTRA -> SALVA1 -> SALVA2.
  - SALVA2: vidas==0 -> FIM_JOGO; else sel!=0 -> TERMINA_MOV; else ESPERA_JOGADA.
  - TERMINA_MOV: wait fim_movimentacao; then vidas==0 -> FIM_JOGO, else INICIA_REGISTRA.
  - INICIA_REGISTRA -> ESPERA_REGISTRA.
  - ESPERA_REGISTRA: fim_registra[k] for selected k -> ESPERA_JOGADA; watchdog reaches TIMEOUT -> ERRO. fim_registra on non-selected channels is ignored.
  - ESPERA_ENVIAR: fim_movimentacao -> FIM_JOGO.
  - FIM_JOGO: iniciar -> INICIALIZA, else stay.
  - ERRO: stays until reset.
- Output decode:
  - reset_reg_jogada in INICIALIZA, RESETA_JOGADA and FIM_JOGO.
  - reset_elementos in INICIALIZA.
  - enable_reg_jogada in REGISTRA.
  - inicia_movimentacao in ESPERA_JOGADA.
  - termina in TERMINA_MOV and ESPERA_ENVIAR.
  - inicia_registra = acao_ativa in INICIA_REGISTRA, else 0.
- Cooldown, per channel i:
  - Counter cd[i] increments each cycle, saturating at COOLDOWN[i]; ready[i] = (cd[i]==COOLDOWN[i]).
  - In INICIALIZA, cd[i] is loaded with COOLDOWN[i], so every channel is ready at game start.
  - Frozen in PAUSA, FIM_JOGO and ERRO.
  - Cleared to 0 in INICIA_REGISTRA for the selected channel only.
  - COOLDOWN[i]=0 means always ready.
- Arbitration: sel = lowest-index bit of (acao_pedida & ready). acao_ativa <= sel on the SALVA2 clock edge; acao_ativa is cleared on entry to ESPERA_JOGADA and in INICIALIZA. Exactly one bit of inicia_registra is set, for exactly 1 cycle.
- Watchdog: 8-bit counter, zeroed on entry to ESPERA_REGISTRA, increments each cycle in that state. fim_registra arriving in the same cycle the count reaches TIMEOUT wins, so the FSM goes to ESPERA_JOGADA, not ERRO.
- Reset mid-operation: asynchronous return to INICIAL from any state; start pulses deassert immediately.

Test Plan:
- Defaults: reset=0, then iniciar=1 for 1 cycle -> db_estado 0,1,2; reset_elementos high exactly 1 cycle; inicia_movimentacao=1 in state 2.
- Arbitration: vidas=3, ocorreu_jogada=1, acao_pedida=2'b11 -> states 13,3,8,9,4. Then fim_movimentacao=1 -> state 7 with inicia_registra=2'b01 for 1 cycle. Then fim_registra=2'b01 -> state 2.
- Cooldown: repeat the play 2 cycles after returning to state 2 with acao_pedida=2'b01 (cd[0]=2<20) -> SALVA2 returns to state 2, no inicia_registra. Same with acao_pedida=2'b11 -> channel 1 selected (inicia_registra=2'b10).
- Pause: pausar=1 in state 2 -> state 10, pausado=1, inicia_movimentacao=0, cd values unchanged over 10 cycles. pausar=0 -> state 2.
- Game over: vidas=0 in state 2 -> state 12, termina=1. fim_movimentacao -> state 6, pronto=1. iniciar -> state 1.
- Watchdog/reset: TIMEOUT=4, fim_registra held 0 -> ERRO (31) 4 cycles after entering state 5, erro=1. reset=0 asynchronously mid-cycle -> state 0, all outputs 0.

Source files
------------

// File: rtl/uc_jogo_principal_multiacao.sv
// uc_jogo_principal_multiacao: main game control unit with N action channels, per-channel cooldown,
// fixed-priority arbitration, pause, registration watchdog and restart from game over.
module uc_jogo_principal_multiacao #(
  parameter int N_ACOES = 2,
  parameter int CD_W = 8,
  parameter logic [N_ACOES*CD_W-1:0] COOLDOWN = {8'd20, 8'd5},
  parameter int VIDAS_W = 2,
  parameter int TIMEOUT = 255
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic               pausar,
  input  logic [VIDAS_W-1:0] vidas,
  input  logic               ocorreu_jogada,
  input  logic [N_ACOES-1:0] acao_pedida,
  input  logic               fim_movimentacao,
  input  logic [N_ACOES-1:0] fim_registra,
  output logic               enable_reg_jogada,
  output logic               reset_reg_jogada,
  output logic               reset_elementos,
  output logic               inicia_movimentacao,
  output logic               termina,
  output logic [N_ACOES-1:0] inicia_registra,
  output logic [N_ACOES-1:0] acao_ativa,
  output logic               pausado,
  output logic               pronto,
  output logic               erro,
  output logic [4:0]         db_estado
);
  typedef enum logic [4:0] {
    INICIAL         = 5'd0,
    INICIALIZA      = 5'd1,
    ESPERA_JOGADA   = 5'd2,
    REGISTRA        = 5'd3,
    TERMINA_MOV     = 5'd4,
    ESPERA_REGISTRA = 5'd5,
    FIM_JOGO        = 5'd6,
    INICIA_REGISTRA = 5'd7,
    SALVA1          = 5'd8,
    SALVA2          = 5'd9,
    PAUSA           = 5'd10,
    ESPERA_ENVIAR   = 5'd12,
    RESETA_JOGADA   = 5'd13,
    ERRO            = 5'd31
  } estado_t;

  localparam logic [7:0] WD_MAX = 8'(TIMEOUT - 1);

  estado_t estado, nxt;
  logic [N_ACOES-1:0][CD_W-1:0] cd;
  logic [N_ACOES-1:0] ready, pedido, sel;
  logic [7:0] wd;
  logic sem_vidas, congelado;

  for (genvar g = 0; g < N_ACOES; g++) begin : g_ready
    assign ready[g] = cd[g] == COOLDOWN[g*CD_W +: CD_W];
  end

  // lowest set bit of the ready requests wins (bit 0 highest priority)
  assign pedido = acao_pedida & ready;
  assign sel = pedido & (~pedido + N_ACOES'(1));
  assign sem_vidas = vidas == '0;
  assign congelado = estado inside {PAUSA, FIM_JOGO, ERRO};

  always_comb begin
    nxt = ERRO;
    case (estado)
      INICIAL:         nxt = iniciar ? INICIALIZA : INICIAL;
      INICIALIZA:      nxt = ESPERA_JOGADA;
      ESPERA_JOGADA:   nxt = sem_vidas ? ESPERA_ENVIAR : pausar ? PAUSA :
                             ocorreu_jogada ? RESETA_JOGADA : ESPERA_JOGADA;
      PAUSA:           nxt = pausar ? PAUSA : ESPERA_JOGADA;
      RESETA_JOGADA:   nxt = REGISTRA;
      REGISTRA:        nxt = SALVA1;
      SALVA1:          nxt = SALVA2;
      SALVA2:          nxt = sem_vidas ? FIM_JOGO : |sel ? TERMINA_MOV : ESPERA_JOGADA;
      TERMINA_MOV:     nxt = !fim_movimentacao ? TERMINA_MOV : sem_vidas ? FIM_JOGO : INICIA_REGISTRA;
      INICIA_REGISTRA: nxt = ESPERA_REGISTRA;
      ESPERA_REGISTRA: nxt = |(fim_registra & acao_ativa) ? ESPERA_JOGADA :
                             wd == WD_MAX ? ERRO : ESPERA_REGISTRA;
      ESPERA_ENVIAR:   nxt = fim_movimentacao ? FIM_JOGO : ESPERA_ENVIAR;
      FIM_JOGO:        nxt = iniciar ? INICIALIZA : FIM_JOGO;
      default:         nxt = ERRO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado              <= INICIAL;
      db_estado           <= '0;
      cd                  <= '0;
      wd                  <= '0;
      acao_ativa          <= '0;
      enable_reg_jogada   <= 1'b0;
      reset_reg_jogada    <= 1'b0;
      reset_elementos     <= 1'b0;
      inicia_movimentacao <= 1'b0;
      termina             <= 1'b0;
      inicia_registra     <= '0;
      pausado             <= 1'b0;
      pronto              <= 1'b0;
      erro                <= 1'b0;
    end else begin
      estado              <= nxt;
      db_estado           <= nxt;
      enable_reg_jogada   <= nxt == REGISTRA;
      reset_reg_jogada    <= nxt inside {INICIALIZA, RESETA_JOGADA, FIM_JOGO};
      reset_elementos     <= nxt == INICIALIZA;
      inicia_movimentacao <= nxt == ESPERA_JOGADA;
      termina             <= nxt inside {TERMINA_MOV, ESPERA_ENVIAR};
      inicia_registra     <= nxt == INICIA_REGISTRA ? acao_ativa : '0;
      pausado             <= nxt == PAUSA;
      pronto              <= nxt == FIM_JOGO;
      erro                <= nxt == ERRO;
      wd                  <= estado == INICIA_REGISTRA ? 8'd0 : estado == ESPERA_REGISTRA ? wd + 8'd1 : wd;
      acao_ativa          <= estado == SALVA2 ? sel : nxt == ESPERA_JOGADA ? '0 : acao_ativa;
      for (int i = 0; i < N_ACOES; i++)
        cd[i] <= estado == INICIALIZA ? COOLDOWN[i*CD_W +: CD_W] :
                 (estado == INICIA_REGISTRA && acao_ativa[i]) ? '0 :
                 (congelado || ready[i]) ? cd[i] : cd[i] + CD_W'(1);
    end
  end
endmodule

// File: tb/tb_uc_jogo_principal_multiacao.sv
// tb_uc_jogo_principal_multiacao: directed vector table for the game-flow corner cases,
// then randomized play checked against a behavioural model of the game rules.
module tb_uc_jogo_principal_multiacao;
  localparam int TO = 4;

  logic clock = 1'b0, reset = 1'b0, iniciar = 1'b0, pausar = 1'b0;
  logic ocorreu_jogada = 1'b0, fim_movimentacao = 1'b0;
  logic [1:0] vidas = 2'd3, acao_pedida = '0, fim_registra = '0;
  logic enable_reg_jogada, reset_reg_jogada, reset_elementos, inicia_movimentacao;
  logic termina, pausado, pronto, erro;
  logic [1:0] inicia_registra, acao_ativa;
  logic [4:0] db_estado;
  logic [7:0] flags;

  // channel 0 has the long cooldown (20), channel 1 the short one (5)
  uc_jogo_principal_multiacao #(
    .N_ACOES(2), .CD_W(8), .COOLDOWN({8'd5, 8'd20}), .VIDAS_W(2), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .pausar(pausar), .vidas(vidas),
    .ocorreu_jogada(ocorreu_jogada), .acao_pedida(acao_pedida),
    .fim_movimentacao(fim_movimentacao), .fim_registra(fim_registra),
    .enable_reg_jogada(enable_reg_jogada), .reset_reg_jogada(reset_reg_jogada),
    .reset_elementos(reset_elementos), .inicia_movimentacao(inicia_movimentacao),
    .termina(termina), .inicia_registra(inicia_registra), .acao_ativa(acao_ativa),
    .pausado(pausado), .pronto(pronto), .erro(erro), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  assign flags = {enable_reg_jogada, reset_reg_jogada, reset_elementos, inicia_movimentacao,
                  termina, pausado, pronto, erro};

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] flags_of(input int s);
    return {s == 3, s == 1 || s == 13 || s == 6, s == 1, s == 2,
            s == 4 || s == 12, s == 10, s == 6, s == 31};
  endfunction

  task automatic chk_all(input string tag, input int s, input logic [1:0] ir, input logic [1:0] aa);
    chk({tag, ".estado"}, 32'(db_estado), s);
    chk({tag, ".saidas"}, 32'(flags), 32'(flags_of(s)));
    chk({tag, ".inicia_registra"}, 32'(inicia_registra), 32'(ir));
    chk({tag, ".acao_ativa"}, 32'(acao_ativa), 32'(aa));
  endtask

  typedef struct {
    logic rs, ini, pau, oc, fm;
    logic [1:0] vid, ap, fr, ir, aa;
    int st;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(input int rs, ini, pau, vid, oc, ap, fm, fr, st, ir, aa);
    vec_t v;
    v.rs = 1'(rs); v.ini = 1'(ini); v.pau = 1'(pau); v.vid = 2'(vid); v.oc = 1'(oc);
    v.ap = 2'(ap); v.fm = 1'(fm); v.fr = 2'(fr); v.st = st; v.ir = 2'(ir); v.aa = 2'(aa);
    return v;
  endfunction

  task automatic drive(input logic rs, ini, pau, input logic [1:0] vid, input logic oc,
                       input logic [1:0] ap, input logic fm, input logic [1:0] fr);
    reset = rs; iniciar = ini; pausar = pau; vidas = vid; ocorreu_jogada = oc;
    acao_pedida = ap; fim_movimentacao = fm; fim_registra = fr;
  endtask

  // behavioural model: game phase by its debug code, cooldowns as saturating ages
  int ms, mwd;
  int mcd[2];
  int cdmax[2] = '{20, 5};
  logic [1:0] maa;

  task automatic m_reset();
    ms = 0; mwd = 0; mcd[0] = 0; mcd[1] = 0; maa = '0;
  endtask

  task automatic m_step(input logic ini, pau, input logic [1:0] vid, input logic oc,
                        input logic [1:0] ap, input logic fm, input logic [1:0] fr);
    int ns;
    logic [1:0] sel;
    sel = '0;
    for (int i = 1; i >= 0; i--) if (ap[i] && mcd[i] >= cdmax[i]) sel = 2'(1 << i);
    ns = ms;
    case (ms)
      0:  ns = ini ? 1 : 0;
      1:  ns = 2;
      2:  ns = (vid == 0) ? 12 : pau ? 10 : oc ? 13 : 2;
      10: ns = pau ? 10 : 2;
      13: ns = 3;
      3:  ns = 8;
      8:  ns = 9;
      9:  ns = (vid == 0) ? 6 : (sel != 0) ? 4 : 2;
      4:  ns = !fm ? 4 : (vid == 0) ? 6 : 7;
      7:  ns = 5;
      5:  ns = ((fr & maa) != 0) ? 2 : (mwd + 1 >= TO) ? 31 : 5;
      12: ns = fm ? 6 : 12;
      6:  ns = ini ? 1 : 6;
      default: ns = 31;
    endcase
    for (int i = 0; i < 2; i++) begin
      if (ms == 1) mcd[i] = cdmax[i];
      else if (ms == 7 && maa[i]) mcd[i] = 0;
      else if (!(ms == 10 || ms == 6 || ms == 31) && mcd[i] < cdmax[i]) mcd[i]++;
    end
    if (ms == 7) mwd = 0;
    else if (ms == 5) mwd++;
    if (ms == 9) maa = sel;
    else if (ns == 2) maa = '0;
    ms = ns;
  endtask

  initial begin
    // rs ini pau vid oc ap fm fr | st ir aa
    tv.push_back(mk(1,1,0,3,0,0,0,0,  1,0,0));
    tv.push_back(mk(1,0,0,3,0,0,0,0,  2,0,0));
    tv.push_back(mk(1,0,0,3,1,3,0,0, 13,0,0));
    tv.push_back(mk(1,0,0,3,0,3,0,0,  3,0,0));
    tv.push_back(mk(1,0,0,3,0,3,0,0,  8,0,0));
    tv.push_back(mk(1,0,0,3,0,3,0,0,  9,0,0));
    tv.push_back(mk(1,0,0,3,0,3,0,0,  4,0,1));
    tv.push_back(mk(1,0,0,3,0,0,0,0,  4,0,1));
    tv.push_back(mk(1,0,0,3,0,0,1,0,  7,1,1));
    tv.push_back(mk(1,0,0,3,0,0,0,0,  5,0,1));
    tv.push_back(mk(1,0,0,3,0,0,0,2,  5,0,1));
    tv.push_back(mk(1,0,0,3,0,0,0,1,  2,0,0));
    // channel 0 still cooling down: play falls back to waiting
    tv.push_back(mk(1,0,0,3,1,1,0,0, 13,0,0));
    tv.push_back(mk(1,0,0,3,0,1,0,0,  3,0,0));
    tv.push_back(mk(1,0,0,3,0,1,0,0,  8,0,0));
    tv.push_back(mk(1,0,0,3,0,1,0,0,  9,0,0));
    tv.push_back(mk(1,0,0,3,0,1,0,0,  2,0,0));
    // both requested: channel 1 is the only ready one
    tv.push_back(mk(1,0,0,3,1,3,0,0, 13,0,0));
    tv.push_back(mk(1,0,0,3,0,3,0,0,  3,0,0));
    tv.push_back(mk(1,0,0,3,0,3,0,0,  8,0,0));
    tv.push_back(mk(1,0,0,3,0,3,0,0,  9,0,0));
    tv.push_back(mk(1,0,0,3,0,3,0,0,  4,0,2));
    tv.push_back(mk(1,0,0,3,0,0,1,0,  7,2,2));
    tv.push_back(mk(1,0,0,3,0,0,0,0,  5,0,2));
    tv.push_back(mk(1,0,0,3,0,0,0,2,  2,0,0));
    for (int i = 0; i < 10; i++) tv.push_back(mk(1,0,1,3,0,0,0,0, 10,0,0));
    tv.push_back(mk(1,0,0,3,0,0,0,0,  2,0,0));
    // game over and restart
    tv.push_back(mk(1,0,0,0,0,0,0,0, 12,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,0, 12,0,0));
    tv.push_back(mk(1,0,0,0,0,0,1,0,  6,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,0,  6,0,0));
    tv.push_back(mk(1,1,0,0,0,0,0,0,  1,0,0));
    tv.push_back(mk(1,0,0,3,0,0,0,0,  2,0,0));
    // watchdog expiry
    tv.push_back(mk(1,0,0,3,1,1,0,0, 13,0,0));
    tv.push_back(mk(1,0,0,3,0,1,0,0,  3,0,0));
    tv.push_back(mk(1,0,0,3,0,1,0,0,  8,0,0));
    tv.push_back(mk(1,0,0,3,0,1,0,0,  9,0,0));
    tv.push_back(mk(1,0,0,3,0,1,0,0,  4,0,1));
    tv.push_back(mk(1,0,0,3,0,0,1,0,  7,1,1));
    tv.push_back(mk(1,0,0,3,0,0,0,0,  5,0,1));
    tv.push_back(mk(1,0,0,3,0,0,0,2,  5,0,1));
    tv.push_back(mk(1,0,0,3,0,0,0,0,  5,0,1));
    tv.push_back(mk(1,0,0,3,0,0,0,0,  5,0,1));
    tv.push_back(mk(1,0,0,3,0,0,0,0, 31,0,1));
    tv.push_back(mk(1,0,0,3,0,0,0,0, 31,0,1));
    // asynchronous reset out of ERRO, then completion racing the timeout
    tv.push_back(mk(0,0,0,3,0,0,0,0,  0,0,0));
    tv.push_back(mk(1,1,0,3,0,0,0,0,  1,0,0));
    tv.push_back(mk(1,0,0,3,0,0,0,0,  2,0,0));
    tv.push_back(mk(1,0,0,3,1,2,0,0, 13,0,0));
    tv.push_back(mk(1,0,0,3,0,2,0,0,  3,0,0));
    tv.push_back(mk(1,0,0,3,0,2,0,0,  8,0,0));
    tv.push_back(mk(1,0,0,3,0,2,0,0,  9,0,0));
    tv.push_back(mk(1,0,0,3,0,2,0,0,  4,0,2));
    tv.push_back(mk(1,0,0,3,0,0,1,0,  7,2,2));
    tv.push_back(mk(1,0,0,3,0,0,0,0,  5,0,2));
    tv.push_back(mk(1,0,0,3,0,0,0,0,  5,0,2));
    tv.push_back(mk(1,0,0,3,0,0,0,0,  5,0,2));
    tv.push_back(mk(1,0,0,3,0,0,0,0,  5,0,2));
    tv.push_back(mk(1,0,0,3,0,0,0,2,  2,0,0));

    repeat (2) @(negedge clock);
    chk_all("reset", 0, 2'b00, 2'b00);
    foreach (tv[i]) begin
      drive(tv[i].rs, tv[i].ini, tv[i].pau, tv[i].vid, tv[i].oc, tv[i].ap, tv[i].fm, tv[i].fr);
      if (!tv[i].rs) begin
        #1;
        chk_all($sformatf("tab%0d.async", i), 0, 2'b00, 2'b00);
      end
      @(posedge clock);
      @(negedge clock);
      chk_all($sformatf("tab%0d", i), tv[i].st, tv[i].ir, tv[i].aa);
    end

    drive(1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 2'b00, 1'b0, 2'b00);
    m_reset();
    @(posedge clock);
    @(negedge clock);
    chk_all("rnd.reset", ms, 2'b00, maa);
    for (int c = 0; c < 4000; c++) begin
      logic rs, ini, pau, oc, fm;
      logic [1:0] vid, ap, fr;
      rs  = $urandom_range(0, 149) != 0;
      ini = $urandom_range(0, 3) == 0;
      pau = $urandom_range(0, 7) == 0;
      vid = $urandom_range(0, 11) == 0 ? 2'd0 : 2'($urandom_range(1, 3));
      oc  = 1'($urandom_range(0, 1));
      ap  = 2'($urandom_range(0, 3));
      fm  = $urandom_range(0, 2) == 0;
      fr  = $urandom_range(0, 2) == 0 ? 2'($urandom_range(0, 3)) : 2'b00;
      drive(rs, ini, pau, vid, oc, ap, fm, fr);
      if (!rs) m_reset();
      else m_step(ini, pau, vid, oc, ap, fm, fr);
      @(posedge clock);
      @(negedge clock);
      chk_all($sformatf("rnd%0d", c), ms, ms == 7 ? maa : 2'b00, maa);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
